// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, FSM encoding, S-box/inverse S-box,
// inverse bit permutation and the forward/inverse key-schedule steps.
package present_pkg;
  localparam int SIZE       = 64;
  localparam int KEY_SIZE   = 80;
  localparam int NUM_ROUNDS = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEYEXP  = 2'd1,
    ST_DECRYPT = 2'd2,
    ST_FINAL   = 2'd3
  } fsm_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
      4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
      4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
      4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
      4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
      4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
      4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Output bit j takes input bit 16*j mod 63; bit 63 is a fixed point.
  function automatic logic [SIZE-1:0] inv_player(input logic [SIZE-1:0] d);
    logic [SIZE-1:0] r;
    r = '0;
    for (int j = 0; j < 63; j++) r[j] = d[6'((16 * j) % 63)];
    r[63] = d[63];
    return r;
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0] rc);
    logic [KEY_SIZE-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0] rc);
    logic [KEY_SIZE-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction
endpackage

// File: rtl/present_inv_round.sv
// One combinational inverse PRESENT round: add round key, inverse permutation,
// inverse S-layer, plus the matching inverse key-schedule step.
module present_inv_round
  import present_pkg::*;
(
  input  logic [SIZE-1:0]     i_state,
  input  logic [KEY_SIZE-1:0] i_key,
  input  logic [4:0]          i_rc,
  output logic [SIZE-1:0]     o_state,
  output logic [KEY_SIZE-1:0] o_key
);
  logic [SIZE-1:0] w_mix;
  logic [SIZE-1:0] w_perm;

  assign w_mix  = i_state ^ i_key[79:16];
  assign w_perm = inv_player(w_mix);
  assign o_key  = key_inv(i_key, i_rc);

  always_comb begin
    o_state = '0;
    for (int n = 0; n < 16; n++) o_state[4*n +: 4] = inv_sbox(w_perm[4*n +: 4]);
  end
endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: expands the key forward to K32, then unwinds 31
// inverse rounds. Optional PRESENT_DEC_KEYCACHE_EN keeps the last K32 to skip expansion.
module present_decrypt
  import present_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [KEY_SIZE-1:0] i_key,
  input  logic [SIZE-1:0]     i_ciphertext,
  output logic                o_busy,
  output logic                o_done,
  output logic [SIZE-1:0]     o_plaintext,
  output logic [1:0]          o_fsm_state
);
  // Handshake: i_start is taken only in IDLE; o_busy rises the cycle after accept and
  // falls in the same cycle o_done pulses; o_plaintext holds until the next result.
  fsm_t                r_fsm;
  logic                r_busy;
  logic                r_done;
  logic [SIZE-1:0]     r_plain;
  logic [SIZE-1:0]     r_state;
  logic [KEY_SIZE-1:0] r_kreg;
  logic [4:0]          r_rc;
  logic [SIZE-1:0]     w_round_state;
  logic [KEY_SIZE-1:0] w_round_key;
  logic [KEY_SIZE-1:0] w_fwd_key;
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [KEY_SIZE-1:0] r_tag;
  logic [KEY_SIZE-1:0] r_k32;
  logic                r_cache_valid;
`endif

  assign w_fwd_key = key_fwd(r_kreg, r_rc);

  present_inv_round u_round (
    .i_state (r_state),
    .i_key   (r_kreg),
    .i_rc    (r_rc),
    .o_state (w_round_state),
    .o_key   (w_round_key)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fsm   <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_plain <= '0;
      r_state <= '0;
      r_kreg  <= '0;
      r_rc    <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
      r_tag         <= '0;
      r_k32         <= '0;
      r_cache_valid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= i_ciphertext;
            r_busy  <= 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
            if (r_cache_valid && (i_key == r_tag)) begin
              r_kreg <= r_k32;
              r_rc   <= 5'd31;
              r_fsm  <= ST_DECRYPT;
            end else begin
              r_kreg        <= i_key;
              r_rc          <= 5'd1;
              r_tag         <= i_key;
              r_cache_valid <= 1'b0;
              r_fsm         <= ST_KEYEXP;
            end
`else
            r_kreg <= i_key;
            r_rc   <= 5'd1;
            r_fsm  <= ST_KEYEXP;
`endif
          end
        end
        ST_KEYEXP: begin
          r_kreg <= w_fwd_key;
          // rc stays at 31 so the first inverse step uses the last round's counter.
          if (r_rc == 5'd31) begin
            r_fsm <= ST_DECRYPT;
`ifdef PRESENT_DEC_KEYCACHE_EN
            r_k32         <= w_fwd_key;
            r_cache_valid <= 1'b1;
`endif
          end else begin
            r_rc <= r_rc + 5'd1;
          end
        end
        ST_DECRYPT: begin
          r_state <= w_round_state;
          r_kreg  <= w_round_key;
          r_rc    <= r_rc - 5'd1;
          if (r_rc == 5'd1) r_fsm <= ST_FINAL;
        end
        default: begin
          r_plain <= r_state ^ r_kreg[79:16];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_fsm   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_plaintext = r_plain;
  assign o_fsm_state = r_fsm;
endmodule

// File: tb/tb_present_decrypt.sv
// Bench for present_decrypt: known PRESENT-80 vectors plus random blocks enciphered by
// a forward reference cipher; plaintext scoreboard, latency and handshake checks.
module tb_present_decrypt;
  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [79:0] i_key;
  logic [63:0] i_ct;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_plaintext;
  logic [1:0]  o_fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_lat  = 63;
  logic [63:0] exp_q[$];
  logic        tb_cache_valid = 1'b0;
  logic [79:0] tb_cache_tag   = '0;

  localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_decrypt dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_key        (i_key),
    .i_ciphertext (i_ct),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_plaintext  (o_plaintext),
    .o_fsm_state  (o_fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Forward PRESENT-80 encryption straight from the cipher definition.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    logic [4:0]  rc;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_t[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
      s = t;
      rc = 5'(r);
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox_t[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
    end
    return s ^ k[79:16];
  endfunction

  function automatic int exp_latency(input logic [79:0] k);
`ifdef PRESENT_DEC_KEYCACHE_EN
    return (tb_cache_valid && k == tb_cache_tag) ? 32 : 63;
`else
    return 63;
`endif
  endfunction

  // scoreboard: every done pulse must match the oldest outstanding plaintext
  always @(negedge clk) begin
    if (i_rst_n && o_done) begin
      if (exp_q.size() == 0) chk("spurious_done", {79'd0, o_done}, 80'd0);
      else chk("plaintext", {16'd0, o_plaintext}, {16'd0, exp_q.pop_front()});
    end
  end

  // driver tasks (entered and left at a negedge)
  task automatic start_op(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    i_start = 1'b1;
    i_key   = k;
    i_ct    = ct;
    exp_q.push_back(pt);
    cur_lat = exp_latency(k);
    tb_cache_valid = 1'b1;
    tb_cache_tag   = k;
    @(negedge clk);
    i_start = 1'b0;
    i_key   = {16'($urandom), $urandom, $urandom};
    i_ct    = {$urandom, $urandom};
    chk("busy_after_accept", {79'd0, o_busy}, 80'd1);
  endtask

  task automatic wait_done(input int glitch_at);
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      if (n == glitch_at) begin
        i_start = 1'b1;
        i_key   = {16'($urandom), $urandom, $urandom};
        i_ct    = {$urandom, $urandom};
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    chk("latency", 80'(n), 80'(cur_lat));
    chk("busy_at_done", {79'd0, o_busy}, 80'd0);
  endtask

  task automatic run_one(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    start_op(k, ct, pt);
    wait_done(-1);
    @(negedge clk);
    chk("done_pulse", {79'd0, o_done}, 80'd0);
  endtask

  initial begin
    logic [79:0] k;
    logic [63:0] pt;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_key   = '0;
    i_ct    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {79'd0, o_busy}, 80'd0);
    chk("rst_done", {79'd0, o_done}, 80'd0);
    chk("rst_pt", {16'd0, o_plaintext}, 80'd0);
    chk("rst_fsm", {78'd0, o_fsm_state}, 80'd0);
    i_rst_n = 1'b1;
    @(negedge clk);

    // known-answer vectors
    run_one(80'd0,   64'h5579C1387B228445, 64'h0000000000000000);
    run_one(KEY_ONES, 64'hE72C46C0F5945049, 64'h0000000000000000);
    run_one(80'd0,   64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF);
    run_one(KEY_ONES, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF);

    // random blocks, some with a repeated key
    k = {16'($urandom), $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) k = {16'($urandom), $urandom, $urandom};
      pt = {$urandom, $urandom};
      run_one(k, ref_encrypt(pt, k), pt);
    end

    // start while busy is ignored; start in the done cycle is accepted
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    start_op(k, ref_encrypt(pt, k), pt);
    wait_done(10);
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    start_op(k, ref_encrypt(pt, k), pt);
    chk("done_drop_b2b", {79'd0, o_done}, 80'd0);
    wait_done(-1);
    @(negedge clk);

    // reset during cycle 40 discards the block
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    start_op(k, ref_encrypt(pt, k), pt);
    repeat (39) @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {79'd0, o_busy}, 80'd0);
    chk("midrst_done", {79'd0, o_done}, 80'd0);
    chk("midrst_pt", {16'd0, o_plaintext}, 80'd0);
    exp_q.delete();
    tb_cache_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge clk);
    run_one(k, ref_encrypt(pt, k), pt);

    // same key twice, then a new key
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    run_one(k, ref_encrypt(pt, k), pt);
    pt = {$urandom, $urandom};
    run_one(k, ref_encrypt(pt, k), pt);
    k  = {16'($urandom), $urandom, $urandom};
    run_one(k, ref_encrypt(pt, k), pt);

    chk("queue_drained", 80'(exp_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
